// File: rtl/serial_wide_adder_ctrl.sv
// Wide adder sequencer: adds two NBYTES-byte operands one byte per clock
// through a single shared 8-bit binary_adder, LSB first, with a registered
// carry chain between slices. Presents sum/cout/ovf with a one-cycle done.

// Shared 8-bit ripple adder slice.
module binary_adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] SUM,
    output logic       Cout
);
    assign {Cout, SUM} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
endmodule

module serial_wide_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    opa_reg, opb_reg, res_reg, res_next;
    logic            carry_reg;
    logic [IW-1:0]   idx_reg;

    logic [7:0]      a_bytes [NBYTES];
    logic [7:0]      b_bytes [NBYTES];
    logic [7:0]      add_a, add_b, add_sum;
    logic            add_cout;
    logic            last_byte;
    logic            accept;

    // Split the latched operands into byte lanes for the slice mux.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lanes
            assign a_bytes[gi] = opa_reg[gi*8 +: 8];
            assign b_bytes[gi] = opb_reg[gi*8 +: 8];
        end
    endgenerate

    assign add_a     = a_bytes[idx_reg];
    assign add_b     = b_bytes[idx_reg];
    assign last_byte = (idx_reg == IW'(NBYTES - 1));
    // A new request is taken in IDLE or DONE, never while a sequence runs.
    assign accept    = start && (state_reg != RUN);

    binary_adder u_adder (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry_reg),
        .SUM  (add_sum),
        .Cout (add_cout)
    );

    // Result register with the current slice merged in at the active index.
    always_comb begin
        res_next = res_reg;
        res_next[{idx_reg, 3'b000} +: 8] = add_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, carry chain, byte index and internal result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_reg   <= '0;
            opb_reg   <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            opa_reg   <= a;
            opb_reg   <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            res_reg   <= res_next;
            carry_reg <= add_cout;
            idx_reg   <= last_byte ? '0 : idx_reg + 1'b1;
        end
    end

    // Visible results change only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (state_reg == RUN && last_byte) begin
            sum  <= res_next;
            cout <= add_cout;
            ovf  <= (opa_reg[W-1] == opb_reg[W-1]) && (add_sum[7] != opa_reg[W-1]);
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Self-checking bench for serial_wide_adder_ctrl (NBYTES=4): a cycle-level
// behavioural model (countdown + plain 33-bit arithmetic) is compared against
// the DUT on every falling edge, plus literal checks from the scenario list.
module tb_serial_wide_adder_ctrl;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    serial_wide_adder_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_sum, m_pend_sum;
    logic         m_cout, m_pend_cout, m_ovf, m_pend_ovf;

    function automatic logic [W:0] add_full(logic [W-1:0] x, logic [W-1:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ovf_of(logic [W-1:0] x, logic [W-1:0] y, logic c);
        logic [W:0] s;
        s = add_full(x, y, c);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_done <= 1'b0;
            m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
            m_pend_sum <= '0; m_pend_cout <= 1'b0; m_pend_ovf <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_sum  <= m_pend_sum;
                m_cout <= m_pend_cout;
                m_ovf  <= m_pend_ovf;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= NB;
                {m_pend_cout, m_pend_sum} <= add_full(a, b, cin);
                m_pend_ovf <= ovf_of(a, b, cin);
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_left != 0));
        chk("done", W'(done), W'(m_done));
        chk("sum",  sum, m_sum);
        chk("cout", W'(cout), W'(m_cout));
        chk("ovf",  W'(ovf), W'(m_ovf));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk); #1;
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        start = 1'b1; a = av; b = bv; cin = cv;
        cyc();
        start = 1'b0;
        $display("op a=%h b=%h cin=%0d", av, bv, cv);
    endtask

    // Wait for done (bounded) and pin both DUT and model to literal values.
    task automatic wait_done(input string nm, input logic [W-1:0] es, input logic ec,
                             input logic eo, input int exp_lat);
        int n;
        n = 0;
        while (!done && n < 20) begin
            cyc();
            n++;
        end
        chk({nm, "_done_seen"}, W'(done), W'(1));
        if (exp_lat > 0) chk({nm, "_latency"}, W'(n), W'(exp_lat));
        chk({nm, "_sum"},   sum, es);
        chk({nm, "_cout"},  W'(cout), W'(ec));
        chk({nm, "_ovf"},   W'(ovf), W'(eo));
        chk({nm, "_model"}, m_sum, es);
        $display("done %s sum=%h cout=%0d ovf=%0d after %0d cycles", nm, sum, cout, ovf, n);
    endtask

    initial begin
        // Reset held with start and random operands.
        start = 1'b1; a = $urandom; b = $urandom; cin = 1'b1;
        repeat (3) cyc();
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_sum", sum, '0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("idle_done", W'(done), W'(0));

        // Basic add.
        start_op(32'h00000001, 32'h00000001, 1'b0);
        wait_done("basic", 32'h00000002, 1'b0, 1'b0, 4);
        cyc();

        // Full carry ripple and signed overflow.
        start_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_done("ripple", 32'h00000000, 1'b1, 1'b0, 4);
        cyc();
        start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done("ovf", 32'h80000000, 1'b0, 1'b1, 4);
        cyc();

        // Start during RUN is ignored, then back-to-back in DONE.
        start_op(32'h55555555, 32'h00000001, 1'b0);
        cyc();
        start = 1'b1; a = 32'h12345678;
        cyc();
        start = 1'b0;
        wait_done("ignore", 32'h55555556, 1'b0, 1'b0, 0);
        start_op(32'h99999999, 32'h00000000, 1'b1);
        chk("b2b_busy", W'(busy), W'(1));
        wait_done("b2b", 32'h9999999A, 1'b0, 1'b0, 4);
        cyc();

        // Reset in the 3rd RUN cycle discards the operation.
        start_op(32'h67676767, 32'h01010101, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_sum", sum, '0);
        rst_n = 1'b1;
        repeat (6) cyc();
        start_op(32'h00000003, 32'h00000004, 1'b0);
        wait_done("after_abort", 32'h00000007, 1'b0, 1'b0, 4);
        cyc();

        // Randomized traffic: start toggles freely, model checks every cycle.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) != 0);
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            if (i % 50 == 0) a = 32'h7FFFFFFF;
            cyc();
            if (done) $display("rand done sum=%h cout=%0d ovf=%0d", sum, cout, ovf);
        end
        start = 1'b0;
        repeat (8) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_wide_adder_ctrl.md
# serial_wide_adder_ctrl

Sequencer that reuses the team's single 8-bit `binary_adder` (ports A, B, Cin, SUM, Cout) to add two NBYTES-wide operands one byte per clock, least-significant byte first. The block latches the operands on a start request and chains the carry between byte slices through a register. When the last byte completes, it presents the full-width sum, carry-out and signed-overflow flag with a one-cycle done pulse. It sits between a requester that needs wide additions and the existing 8-bit adder datapath, which it instantiates internally.

## Interface
- NBYTES, 4, number of 8-bit slices per operand; legal range 2..16.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, honoured only when not busy.
- a  input  8*NBYTES  operand A; sampled together with start.
- b  input  8*NBYTES  operand B; sampled together with start.
- cin  input  1  carry into byte 0; sampled together with start.
- busy  output  1  high while a byte sequence is in progress (state RUN).
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle on.
- sum  output  8*NBYTES  result, registered, held until the next completion.
- cout  output  1  carry out of the most significant byte, registered.
- ovf  output  1  two's-complement overflow of the full-width add, registered.

## Operation
- The block contains exactly one `binary_adder` instance. Its A and B inputs are the selected byte of the latched operands, and its Cin is the carry register.
- FSM states:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Transitions:
  - IDLE → RUN on start=1. Latch a, b into operand registers, load cin into the carry register, set byte index to 0.
  - RUN, index < NBYTES-1: write adder SUM into result byte [index], load Cout into the carry register, increment index.
  - RUN → DONE when index = NBYTES-1, after the final byte write. On this same edge:
    - copy the full result into `sum`;
    - set `cout` to the final Cout;
    - set `ovf` to (a_msb == b_msb) && (sum_msb != a_msb).
  - DONE → IDLE when start=0.
  - DONE → RUN when start=1 (back-to-back; a new operation is latched exactly as from IDLE).
- start while in RUN is ignored: operands are not relatched and no request is queued.
- The internal result register is separate from `sum`. `sum`, `cout` and `ovf` do not change during RUN; they change only on the completion edge.
- Arithmetic is unsigned modulo 2^(8*NBYTES) for `sum`. `cout` is bit 8*NBYTES of a + b + cin.
- busy = (state == RUN). done = (state == DONE).
- Reset, asserted at any time including mid-RUN:
  - state goes to IDLE;
  - index, carry, operand and result registers clear to 0;
  - the in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0.
- Let E0 be the edge that samples start=1 in IDLE or DONE.
  - busy is high after E0 through edge E(NBYTES).
  - Byte k is computed during the cycle after edge E(k) and written at edge E(k+1).
  - done is high during the cycle after edge E(NBYTES): NBYTES cycles after E0.
- Throughput: one NBYTES-byte add per NBYTES+1 cycles, with start held or re-asserted during the DONE cycle.
- The carry path between bytes is registered; the combinational path is one 8-bit adder.
- `rst_n` assertion acts asynchronously. Deassertion is assumed synchronous to clk.

## Test plan
All scenarios use NBYTES=4.
- Reset:
  - Stimulus: rst_n=0 with start=1 and random operands.
  - Required response: busy=0, done=0, sum=0x00000000, cout=0, ovf=0. After release with start=0, outputs stay unchanged.
- Basic add:
  - Stimulus: a=0x00000001, b=0x00000001, cin=0, start pulsed one cycle.
  - Required response: busy high 4 cycles, then done high 1 cycle with sum=0x00000002, cout=0, ovf=0. `sum` unchanged (0) while busy.
- Full carry ripple:
  - Stimulus: a=0xFFFFFFFF, b=0x00000000, cin=1.
  - Required response: sum=0x00000000, cout=1, ovf=0.
  - Stimulus: a=0x7FFFFFFF, b=0x00000001, cin=0.
  - Required response: sum=0x80000000, cout=0, ovf=1.
- Start during RUN and back-to-back:
  - Stimulus: a=0x55555555, b=0x00000001, cin=0; re-pulse start in the 2nd RUN cycle with a=0x12345678.
  - Required response: the re-pulse is ignored; result sum=0x55555556.
  - Stimulus: hold start=1 in the DONE cycle with a=0x99999999, b=0, cin=1.
  - Required response: the next done has sum=0x9999999A, ovf=0, with no IDLE cycle between operations.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 in the 3rd RUN cycle of a=0x67676767 + b=0x01010101; release, then issue 0x00000003 + 0x00000004.
  - Required response: no done for the aborted add; the new op returns sum=0x00000007 after 4 cycles.
